regfile_writeback: RTL and testbench

//  Owns the regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).

---
 rtl/regfile_writeback_pkg.sv | 22 ++
 rtl/regfile_writeback_fifo.sv | 65 ++++++
 rtl/regfile_writeback.sv | 94 +++++++++
 tb/tb_regfile_writeback.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared types and sizes for the regfile write-back path.
// Holds the buffered result entry and the destination one-hot helper.
package regfile_writeback_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   // r0 is hardwired, so it never marks a pending destination
   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] mask;
      mask = '0;
      if (rd != '0) mask[rd] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// In-order buffer for mult/div results with per-entry valid bits.
// The valid bits feed the pending-destination mask used by hazard logic.
module wb_fifo
   import regfile_writeback_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clock,
   input  logic                ctrl_reset_n,
   input  logic                push,
   input  wb_entry_t           push_entry,
   input  logic                pop,
   output wb_entry_t           head,
   output logic                full,
   output logic                empty,
   output logic [NUM_REGS-1:0] pending_mask
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [DEPTH-1:0] entry_valid;
   wb_entry_t        mem [DEPTH];
   logic             push_en;
   logic             pop_en;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = mem[rd_ptr[IDX_W-1:0]];

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         entry_valid <= '0;
      end else begin
         if (push_en) begin
            wr_ptr                          <= wr_ptr + PTR_W'(1);
            entry_valid[wr_ptr[IDX_W-1:0]] <= 1'b1;
         end
         if (pop_en) begin
            rd_ptr                          <= rd_ptr + PTR_W'(1);
            entry_valid[rd_ptr[IDX_W-1:0]] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push_en) mem[wr_ptr[IDX_W-1:0]] <= push_entry;
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) pending_mask = pending_mask | rd_onehot(mem[i].rd);
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and buffered mult/div results onto the single regfile write port.
// ALU normally wins; a starve counter forces the FIFO head through periodically.
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0]     alu_data,
   output logic                  alu_stall,
   input  logic                  md_valid,
   output logic                  md_ready,
   input  logic [REG_ADDR_W-1:0] md_rd,
   input  logic [DATA_W-1:0]     md_data,
   output logic                  ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0] ctrl_writeReg,
   output logic [DATA_W-1:0]     data_writeReg,
   output logic [NUM_REGS-1:0]   pending_mask
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   wb_entry_t             fifo_head;
   wb_entry_t             md_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  win_alu;
   logic                  win_fifo;
   logic [REG_ADDR_W-1:0] win_rd;
   logic [DATA_W-1:0]     win_data;
   logic [STARVE_W-1:0]   starve_cnt;
   logic [STARVE_W-1:0]   starve_next;

   assign md_entry = '{rd: md_rd, data: md_data};
   assign md_ready = !fifo_full;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .push         (md_valid),
      .push_entry   (md_entry),
      .pop          (win_fifo),
      .head         (fifo_head),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .pending_mask (pending_mask)
   );

   always_comb begin
      win_alu     = 1'b0;
      win_fifo    = 1'b0;
      alu_stall   = 1'b0;
      win_rd      = alu_rd;
      win_data    = alu_data;
      starve_next = '0;
      if (!fifo_empty && (starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
         win_fifo  = 1'b1;
         alu_stall = alu_valid;
      end else if (alu_valid) begin
         win_alu = 1'b1;
         if (!fifo_empty) starve_next = starve_cnt + STARVE_W'(1);
      end else if (!fifo_empty) begin
         win_fifo = 1'b1;
      end
      if (win_fifo) begin
         win_rd   = fifo_head.rd;
         win_data = fifo_head.data;
      end
   end

   // rd=0 winners are consumed but never reach the regfile; reg/data hold
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         starve_cnt       <= '0;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
      end else begin
         starve_cnt       <= starve_next;
         ctrl_writeEnable <= (win_alu || win_fifo) && (win_rd != '0);
         if ((win_alu || win_fifo) && (win_rd != '0)) begin
            ctrl_writeReg <= win_rd;
            data_writeReg <= win_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scenario bench for regfile_writeback: expected writes are queued as stimulus
// is driven and popped by a write-port monitor; each task also checks inline.
module tb_regfile_writeback;
   import regfile_writeback_pkg::*;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] pending_mask;

   int          errors = 0;
   int          checks = 0;
   logic [36:0] exp_q[$];
   logic [36:0] exp_w;

   regfile_writeback #(
      .FIFO_DEPTH   (4),
      .STARVE_LIMIT (3)
   ) dut (
      .clock            (clock),
      .ctrl_reset_n     (ctrl_reset_n),
      .alu_valid        (alu_valid),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .alu_stall        (alu_stall),
      .md_valid         (md_valid),
      .md_ready         (md_ready),
      .md_rd            (md_rd),
      .md_data          (md_data),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .pending_mask     (pending_mask)
   );

   always #5 clock = ~clock;

   // Every write seen on the port must match the head of the expected queue
   always @(negedge clock) begin
      if (ctrl_writeEnable !== 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%h, required no write",
                     ctrl_writeReg, data_writeReg);
         end else begin
            exp_w = exp_q.pop_front();
            if ({ctrl_writeReg, data_writeReg} !== exp_w) begin
               errors++;
               $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                        ctrl_writeReg, data_writeReg, exp_w[36:32], exp_w[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      md_valid  = 1'b0;
      md_rd     = '0;
      md_data   = '0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      ctrl_reset_n = 1'b0;
      idle_inputs();
      repeat (2) step();
      checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 38'd0) begin
         errors++;
         $display("FAIL reset_port: got we=%0b rd=%0d data=%h, required all zero",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      checks++;
      if (pending_mask !== 32'd0) begin
         errors++;
         $display("FAIL reset_mask: got %h, required 0", pending_mask);
      end
      checks++;
      if (md_ready !== 1'b1 || alu_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: got ready=%0b stall=%0b, required ready=1 stall=0",
                  md_ready, alu_stall);
      end
      @(negedge clock);
      ctrl_reset_n = 1'b1;
      step();
   endtask

   task automatic test_alu_only();
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      #1;
      checks++;
      if (alu_stall !== 1'b0) begin
         errors++;
         $display("FAIL alu_only_stall: got %0b, required 0", alu_stall);
      end
      step();
      idle_inputs();
      checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL alu_only_latency: got we=%0b rd=%0d data=%h, required we=1 rd=5 data=deadbeef",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      step();
      checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL alu_only_hold: got we=%0b rd=%0d data=%h, required we=0 rd=5 data=deadbeef",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
      drain("alu_only");
   endtask

   task automatic test_md_only();
      md_valid = 1'b1;
      md_rd    = 5'd7;
      md_data  = 32'h12345678;
      exp_q.push_back({5'd7, 32'h12345678});
      #1;
      checks++;
      if (md_ready !== 1'b1) begin
         errors++;
         $display("FAIL md_only_ready: got %0b, required 1", md_ready);
      end
      step();
      idle_inputs();
      checks++;
      if (pending_mask !== 32'h0000_0080) begin
         errors++;
         $display("FAIL md_only_mask_set: got %h, required 00000080", pending_mask);
      end
      step();
      checks++;
      if ({ctrl_writeEnable, ctrl_writeReg} !== {1'b1, 5'd7}) begin
         errors++;
         $display("FAIL md_only_latency: got we=%0b rd=%0d, required we=1 rd=7",
                  ctrl_writeEnable, ctrl_writeReg);
      end
      checks++;
      if (pending_mask !== 32'd0) begin
         errors++;
         $display("FAIL md_only_mask_clear: got %h, required 0", pending_mask);
      end
      drain("md_only");
   endtask

   task automatic test_duplicate_rd();
      for (int k = 0; k < 2; k++) begin
         md_valid = 1'b1;
         md_rd    = 5'd12;
         md_data  = 32'h0000_1000 + 32'(k);
         exp_q.push_back({5'd12, 32'h0000_1000 + 32'(k)});
         step();
         checks++;
         if (pending_mask !== 32'h0000_1000) begin
            errors++;
            $display("FAIL dup_mask_%0d: got %h, required 00001000", k, pending_mask);
         end
      end
      idle_inputs();
      step();
      checks++;
      if (pending_mask !== 32'd0) begin
         errors++;
         $display("FAIL dup_mask_clear: got %h, required 0", pending_mask);
      end
      drain("duplicate");
   endtask

   task automatic test_starvation();
      int ai = 0;
      logic exp_stall;
      md_valid = 1'b1;
      md_rd    = 5'd9;
      md_data  = 32'hA5A5A5A5;
      step();
      idle_inputs();
      for (int c = 1; c <= 5; c++) begin
         alu_valid = 1'b1;
         alu_rd    = 5'(10 + ai);
         alu_data  = 32'hA000_0000 + 32'(ai);
         exp_stall = (c == 4);
         if (exp_stall) exp_q.push_back({5'd9, 32'hA5A5A5A5});
         else           exp_q.push_back({5'(10 + ai), 32'hA000_0000 + 32'(ai)});
         #1;
         checks++;
         if (alu_stall !== exp_stall) begin
            errors++;
            $display("FAIL starve_stall_c%0d: got %0b, required %0b", c, alu_stall, exp_stall);
         end
         step();
         if (!exp_stall) ai++;
      end
      idle_inputs();
      drain("starvation");
   endtask

   task automatic test_full();
      int   ai = 0;
      int   m  = 0;
      logic exp_ready;
      logic exp_stall;
      for (int c = 0; c <= 5; c++) begin
         exp_ready = (c != 4);
         exp_stall = (c == 4);
         md_valid  = 1'b1;
         md_rd     = 5'(16 + m);
         md_data   = 32'hB000_0000 + 32'(m);
         alu_valid = 1'b1;
         alu_rd    = 5'(1 + ai);
         alu_data  = 32'hC000_0000 + 32'(ai);
         if (exp_stall) exp_q.push_back({5'd16, 32'hB000_0000});
         else           exp_q.push_back({5'(1 + ai), 32'hC000_0000 + 32'(ai)});
         #1;
         checks++;
         if (md_ready !== exp_ready) begin
            errors++;
            $display("FAIL full_ready_c%0d: got %0b, required %0b", c, md_ready, exp_ready);
         end
         checks++;
         if (alu_stall !== exp_stall) begin
            errors++;
            $display("FAIL full_stall_c%0d: got %0b, required %0b", c, alu_stall, exp_stall);
         end
         if (c == 4) begin
            checks++;
            if (pending_mask !== 32'h000F_0000) begin
               errors++;
               $display("FAIL full_mask: got %h, required 000f0000", pending_mask);
            end
         end
         step();
         if (exp_ready) m++;
         if (!exp_stall) ai++;
      end
      idle_inputs();
      for (int k = 1; k <= 4; k++) exp_q.push_back({5'(16 + k), 32'hB000_0000 + 32'(k)});
      drain("full");
   endtask

   task automatic test_rd_zero();
      alu_valid = 1'b1;
      alu_rd    = 5'd0;
      alu_data  = 32'hFFFF_FFFF;
      md_valid  = 1'b1;
      md_rd     = 5'd0;
      md_data   = 32'hEEEE_EEEE;
      step();
      idle_inputs();
      checks++;
      if (ctrl_writeEnable !== 1'b0 || pending_mask !== 32'd0) begin
         errors++;
         $display("FAIL rd0_alu: got we=%0b mask=%h, required we=0 mask=0",
                  ctrl_writeEnable, pending_mask);
      end
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL rd0_md: got we=%0b ready=%0b, required we=0 ready=1",
                  ctrl_writeEnable, md_ready);
      end
      md_valid = 1'b1;
      md_rd    = 5'd3;
      md_data  = 32'h0000_0033;
      exp_q.push_back({5'd3, 32'h0000_0033});
      step();
      idle_inputs();
      step();
      checks++;
      if ({ctrl_writeEnable, ctrl_writeReg} !== {1'b1, 5'd3}) begin
         errors++;
         $display("FAIL rd0_followup: got we=%0b rd=%0d, required we=1 rd=3",
                  ctrl_writeEnable, ctrl_writeReg);
      end
      drain("rd_zero");
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         md_valid  = 1'b1;
         md_rd     = 5'(21 + k);
         md_data   = 32'hD000_0000 + 32'(k);
         alu_valid = 1'b1;
         alu_rd    = 5'(1 + k);
         alu_data  = 32'hE000_0000 + 32'(k);
         exp_q.push_back({5'(1 + k), 32'hE000_0000 + 32'(k)});
         step();
      end
      idle_inputs();
      checks++;
      if (pending_mask !== 32'h00E0_0000) begin
         errors++;
         $display("FAIL rst_mid_queued: got %h, required 00e00000", pending_mask);
      end
      @(negedge clock);
      #1;
      ctrl_reset_n = 1'b0;
      #1;
      checks++;
      if (ctrl_writeEnable !== 1'b0 || pending_mask !== 32'd0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_immediate: got we=%0b mask=%h ready=%0b, required we=0 mask=0 ready=1",
                  ctrl_writeEnable, pending_mask, md_ready);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      ctrl_reset_n = 1'b1;
      repeat (8) step();
      checks++;
      if (exp_q.size() != 0 || md_ready !== 1'b1 || pending_mask !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_after: got outstanding=%0d ready=%0b mask=%h, required 0/1/0",
                  exp_q.size(), md_ready, pending_mask);
      end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_md_only();
      test_duplicate_rd();
      test_starvation();
      test_full();
      test_rd_zero();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
